// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end that time-shares one combinational 8x8 Wallace-tree
// multiplier among NREQ requesters, returning tagged 16-bit products.

// Purpose: unsigned 8x8 multiply using a carry-save (Wallace) reduction tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module Wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] out
);

  logic [15:0] pp [8];

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = {8'b0, a & {8{b[i]}}} << i;
  end

  // 3:2 compressor across whole rows; carries move one column left.
  function automatic logic [31:0] csa(input logic [15:0] x,
                                      input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3, s4, c4;

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  assign {c1a, s1a} = csa(pp[0], pp[1], pp[2]);
  assign {c1b, s1b} = csa(pp[3], pp[4], pp[5]);
  assign {c2a, s2a} = csa(s1a, c1a, s1b);
  assign {c2b, s2b} = csa(c1b, pp[6], pp[7]);
  assign {c3, s3}   = csa(s2a, c2a, s2b);
  assign {c4, s4}   = csa(s3, c3, c2b);
  assign out        = s4 + c4;

endmodule

// Purpose: round-robin arbitration of NREQ clients onto one shared multiplier.
// Latency: grant edge to res_valid is 2 clocks; one operation per 2 clocks peak.
// Backpressure: result held until res_ready; new grants only when the result slot frees.
module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [15:0]         res_product,
  input  logic                res_ready,
  output logic                busy,
  output logic [15:0]         op_count
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  op_id;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [15:0]     mul_out;

  logic [NREQ-1:0] rot;
  logic            gnt_any;
  int              gnt_off;
  int              gnt_sum;
  logic [IDW-1:0]  gnt_idx;
  logic            can_accept;
  logic            grant;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;

  Wallace u_mul (
    .a   (op_a),
    .b   (op_b),
    .out (mul_out)
  );

  // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
  assign rot = NREQ'({req_valid, req_valid} >> ptr);

  always_comb begin
    gnt_any = 1'b0;
    gnt_off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        gnt_off = k;
      end
    end
  end

  assign gnt_sum = int'(ptr) + gnt_off;
  assign gnt_idx = IDW'((gnt_sum >= NREQ) ? (gnt_sum - NREQ) : gnt_sum);

  // Reset gates the grant so req_ready is low throughout reset.
  assign can_accept = rst_n && ((state == IDLE) || ((state == DONE) && res_ready));
  assign grant      = can_accept && gnt_any;

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a        = req_a[8*i +: 8];
        sel_b        = req_b[8*i +: 8];
        req_ready[i] = grant;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_product <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
        end
        COMPUTE: begin
          res_product <= mul_out;
          res_id      <= op_id;
          res_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            op_count  <= op_count + 16'd1;
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A grant overrides the IDLE fall-back above, giving back-to-back issue.
      if (grant) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        state <= COMPUTE;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Self-checking bench for wallace_mul_arbiter: directed vectors plus a
// randomized run scored against a queue-based reference model.
module tb_wallace_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_product;
  logic              res_ready;
  logic              busy;
  logic [15:0]       op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  wallace_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_product (res_product),
    .res_ready   (res_ready),
    .busy        (busy),
    .op_count    (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Starts and ends one time unit after a rising edge, with the DUT idle.
  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_valid = oh;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    res_ready = 1'b0;
    @(negedge clk);
    check("op_grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("op_compute_valid", res_valid, 0);
    check("op_compute_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("op_done_valid", res_valid, 1);
    check("op_product", res_product, p);
    check("op_id", res_id, id);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt++;
    check("op_count", op_count, 16'(exp_cnt));
    check("op_idle_busy", busy, 0);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] p;
    int          t;
  } exp_t;

  vec_t        tbl [5];
  exp_t        q [$];
  logic [7:0]  pa [NREQ];
  logic [7:0]  pb [NREQ];
  bit          pend [NREQ];
  logic [7:0]  fa [NREQ];
  logic [7:0]  fb [NREQ];

  initial begin
    int          m_ptr;
    int          g;
    int          j;
    bit          vis;
    bit          can;
    logic [15:0] prod;
    logic [NREQ-1:0] exp_rdy;

    tbl[0] = '{0, 8'h0C, 8'h0D, 16'h009C};
    tbl[1] = '{2, 8'h00, 8'hFF, 16'h0000};
    tbl[2] = '{2, 8'hFF, 8'hFF, 16'hFE01};
    tbl[3] = '{2, 8'h80, 8'h02, 16'h0100};
    tbl[4] = '{2, 8'h01, 8'h01, 16'h0001};

    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_product", res_product, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    do_reset();

    for (int i = 0; i < 5; i++)
      single_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p);

    // Round-robin with every requester asserting and the consumer always ready.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      fa[i] = 8'(i * 17 + 3);
      fb[i] = 8'(i * 29 + 5);
      req_a[8*i +: 8] = fa[i];
      req_b[8*i +: 8] = fb[i];
    end
    req_valid = '1;
    res_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_rdy = '0;
      if (c % 2 == 0 && c < 10) exp_rdy[(c / 2) % NREQ] = 1'b1;
      check("rr_grant", req_ready, exp_rdy);
      if (c >= 2 && c % 2 == 0) begin
        j = (c / 2 - 1) % NREQ;
        check("rr_res_valid", res_valid, 1);
        check("rr_res_id", res_id, j);
        check("rr_product", res_product, 16'(fa[j]) * 16'(fb[j]));
      end else begin
        check("rr_res_valid_low", res_valid, 0);
      end
      @(posedge clk); #1;
      if (c == 8) req_valid = '0;
    end
    res_ready = 1'b0;
    exp_cnt = 5;
    check("rr_op_count", op_count, 5);

    // Backpressure: requester 1 waits while result 0 is stalled.
    req_valid = 4'b0001;
    req_a[7:0] = 8'h21;
    req_b[7:0] = 8'h03;
    @(negedge clk);
    check("bp_grant0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_a[15:8] = 8'hF0;
    req_b[15:8] = 8'h11;
    @(negedge clk);
    check("bp_compute_ready", req_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_ready", req_ready, 0);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_product", res_product, 16'h0063);
      check("bp_hold_id", res_id, 0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_b2b_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = '0;
    exp_cnt++;
    @(negedge clk);
    check("bp_b2b_compute", res_valid, 0);
    check("bp_count", op_count, 16'(exp_cnt));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_b2b_valid", res_valid, 1);
    check("bp_b2b_product", res_product, 16'h0FF0);
    check("bp_b2b_id", res_id, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt++;
    check("bp_count2", op_count, 16'(exp_cnt));

    // Reset while COMPUTE: pointer sits at 3 before the reset.
    req_valid = 4'b0100;
    @(negedge clk);
    check("mr_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    rst_n = 1'b0;
    #1;
    check("mr_res_valid", res_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_op_count", op_count, 0);
    check("mr_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("mr_ptr_zero_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_post_product", res_product, 16'h0FF0);
    check("mr_post_id", res_id, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("mr_post_count", op_count, 1);

    // Randomized traffic against the queue/timestamp reference model.
    do_reset();
    m_ptr = 0;
    q.delete();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
        end
        req_valid[i] = pend[i];
        if (pend[i]) begin
          req_a[8*i +: 8] = pa[i];
          req_b[8*i +: 8] = pb[i];
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vis = (q.size() > 0) && (c >= q[0].t + 2);
      check("rnd_res_valid", res_valid, vis);
      if (vis) begin
        check("rnd_res_id", res_id, q[0].id);
        check("rnd_product", res_product, q[0].p);
      end
      check("rnd_op_count", op_count, 16'(exp_cnt));
      can = (q.size() == 0) || (vis && res_ready);
      g = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (g < 0 && pend[j]) g = j;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("rnd_req_ready", req_ready, exp_rdy);
      if (vis && res_ready) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (g >= 0) begin
        prod = 16'(pa[g]) * 16'(pb[g]);
        q.push_back('{g, prod, c});
        m_ptr = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Counter wrap: preload to 0xFFFF, next handoff must read 0.
    do_reset();
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    exp_cnt = 16'hFFFF;
    single_op(3, 8'hFF, 8'hFF, 16'hFE01);
    single_op(1, 8'h07, 8'h09, 16'h003F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
